slow_window_ctrl: RTL
=====================

// Module: slow_window_ctrl
// PURPOSE
//  Sequences accelerator slow-down for accesses to legacy peripherals (IACK, VIA, IWM, SCC, SCSI, sound).
//  Uses the per-device Slow* enables, SlowTimeout and SlowClockGate written by the configuration register block.
//  Handshakes with the CPU clock switcher and stalls the bus cycle until slow mode is confirmed.
//  Holds slow mode for SlowTimeout prescaled ticks after the last enabled slow access.
// PARAMETERS
//  TICK_DIV  4096  CLK cycles per timeout tick (>=2)
//  TICK_W    12    prescaler width = clog2(TICK_DIV)
// PORTS
//  CLK            in   1  system clock; all logic on posedge
//  POR            in   1  reset, asynchronous, active-high
//  BACT           in   1  bus access active
//  IACKCS,VIACS,IWMCS,SCCCS,SCSICS,SndCS  in 1 each  current-cycle address decodes
//  SlowIACK,SlowVIA,SlowIWM,SlowSCC,SlowSCSI,SlowSnd  in 1 each  per-device slow enables
//  SlowClockGate  in   1  gate accelerator clock while slow window held
//  SlowTimeout    in   4  window length in ticks, sampled only at (re)load
//  SlowAck        in   1  clock switcher: 1 = running slow (level, CLK domain)
//  SlowReq        out  1  request slow clock
//  SlowWait       out  1  hold off termination of current bus cycle
//  ClockGate      out  1  accelerator clock gate
//  SlowActive     out  1  status: state==HOLD
// BEHAVIOUR
//  - Hit = BACT & |({IACKCS,VIACS,IWMCS,SCCCS,SCSICS,SndCS} & enables); Hit_r = Hit delayed 1 CLK.
//  - HitStart = Hit & ~Hit_r.
//  - Reset (POR=1, async): state IDLE, cnt=0, presc=0, Hit_r=0.
//    SlowReq, SlowWait(reg part), ClockGate, SlowActive all 0.
//    Asserting POR mid-window drops SlowReq immediately.
//  - FSM, registered, 2-bit:
//    IDLE:    on Hit -> SWITCH; load cnt=SlowTimeout.
//    SWITCH:  SlowReq=1; when SlowAck=1 -> HOLD; clear presc.
//    HOLD:    SlowReq=1.
//             HitStart -> cnt=SlowTimeout, presc=0.
//             Else on tick with cnt!=0 -> cnt-1.
//             When cnt==0 and Hit=0 -> RELEASE.
//    RELEASE: SlowReq=0; when SlowAck=0 -> IDLE.
//             A Hit seen in RELEASE is not aborted: finish the drop, then IDLE re-arms next cycle.
//  - Latency: Hit sampled at edge N -> SlowReq=1 after N.
//    SlowAck seen at edge M -> HOLD after M.
//  - SlowWait = Hit & (state!=HOLD), combinational; deasserts in the same cycle HOLD is entered.
//  - ClockGate = SlowClockGate & (state==HOLD), registered with state.
//  - SlowActive = (state==HOLD).
//  - Prescaler runs only in HOLD; tick when presc==TICK_DIV-1, then wraps to 0.
//  - cnt: 4-bit, never underflows.
//  - SlowTimeout=0: exit HOLD on first cycle with Hit=0.
//  - Back-to-back accesses in HOLD: each HitStart reloads, extending the window.
//  - A slow access held across cnt reaching 0 keeps HOLD until Hit drops.
//  - Config changes mid-window: enable cleared does not end the window; new SlowTimeout applies at next load only.
//  - SlowAck glitch low in HOLD is ignored; SlowAck high in IDLE is ignored.
// STRUCTURE
//  - Shared package: state encoding (IDLE=0, SWITCH=1, HOLD=2, RELEASE=3), TICK_DIV default.
//  - Sub-module slow_tick_prescaler: en, clr -> tick; reused by other timeout logic.
//  - Top holds FSM, cnt and output decode.
// TESTING (TICK_DIV=4 in sim)
//  1. POR pulse mid-HOLD (SlowTimeout=3) -> SlowReq, ClockGate, SlowActive 0 asynchronously; state IDLE after release.
//  2. SlowVIA=1, VIACS+BACT, SlowAck returned 2 cycles after SlowReq, SlowTimeout=3 ->
//     SlowWait high until HOLD; SlowReq drops 12 CLKs after Hit falls; IDLE once SlowAck=0.
//  3. SlowSCSI=0, SCSICS+BACT -> SlowReq, SlowWait stay 0.
//  4. SlowTimeout=2; second SCC access 5 CLKs into HOLD -> cnt reloads to 2; window ends 8 CLKs after second Hit falls.
//  5. SlowTimeout=0, SlowClockGate=1 -> ClockGate high only during HOLD; RELEASE on first Hit=0 cycle.
//  6. IWM Hit during RELEASE with SlowAck still 1 -> SlowWait held.
//     IDLE on SlowAck=0, SWITCH next cycle, HOLD on SlowAck=1 clears SlowWait.

Source files
------------

// File: rtl/slow_window_ctrl_pkg.sv
// rtl/slow_window_ctrl_pkg.sv - shared state encoding and timing defaults for the slow window controller
package slow_window_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SWITCH  = 2'd1,
      ST_HOLD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam int TICK_DIV_DEFAULT = 4096;
   localparam int TICK_W_DEFAULT   = 12;

endpackage

// File: rtl/slow_tick_prescaler.sv
// rtl/slow_tick_prescaler.sv - free-running tick prescaler with enable and synchronous clear
module slow_tick_prescaler
   import slow_window_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int TICK_W   = TICK_W_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   logic [TICK_W-1:0] r_presc;
   logic              w_wrap;

   assign w_wrap = (r_presc == TICK_W'(TICK_DIV - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
      end else if (i_clr) begin
         r_presc <= '0;
      end else if (i_en) begin
         r_presc <= w_wrap ? '0 : r_presc + TICK_W'(1);
      end
   end

   // A clear restarts the period, so it suppresses any tick in the same cycle.
   assign o_tick = i_en & ~i_clr & w_wrap;

endmodule

// File: rtl/slow_window_ctrl.sv
// rtl/slow_window_ctrl.sv - sequences CPU slow-down around accesses to legacy peripherals
module slow_window_ctrl
   import slow_window_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int TICK_W   = TICK_W_DEFAULT
) (
   input  logic       CLK,
   input  logic       POR,
   input  logic       BACT,
   input  logic       IACKCS,
   input  logic       VIACS,
   input  logic       IWMCS,
   input  logic       SCCCS,
   input  logic       SCSICS,
   input  logic       SndCS,
   input  logic       SlowIACK,
   input  logic       SlowVIA,
   input  logic       SlowIWM,
   input  logic       SlowSCC,
   input  logic       SlowSCSI,
   input  logic       SlowSnd,
   input  logic       SlowClockGate,
   input  logic [3:0] SlowTimeout,
   input  logic       SlowAck,
   output logic       SlowReq,
   output logic       SlowWait,
   output logic       ClockGate,
   output logic       SlowActive
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_hit;
   logic       r_clock_gate;
   logic       w_hit;
   logic       w_hit_start;
   logic       w_tick;
   logic       w_presc_en;
   logic       w_presc_clr;

   assign w_hit = BACT & |({IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} &
                           {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd});
   assign w_hit_start = w_hit & ~r_hit;

   assign w_presc_en  = (r_state == ST_HOLD);
   assign w_presc_clr = ((r_state == ST_SWITCH) & SlowAck) |
                        ((r_state == ST_HOLD) & w_hit_start);

   slow_tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (TICK_W)
   ) u_prescaler (
      .i_clk  (CLK),
      .i_rst  (POR),
      .i_en   (w_presc_en),
      .i_clr  (w_presc_clr),
      .o_tick (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               w_state_nxt = ST_SWITCH;
               w_cnt_nxt   = SlowTimeout;
            end
         end
         ST_SWITCH: begin
            if (SlowAck) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (w_hit_start) begin
               w_cnt_nxt = SlowTimeout;
            end else if (w_tick && (r_cnt != 4'd0)) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
            // An access still in flight keeps the window open even once expired.
            if ((r_cnt == 4'd0) && !w_hit) begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!SlowAck) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge POR) begin
      if (POR) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_hit        <= 1'b0;
         r_clock_gate <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_hit        <= w_hit;
         r_clock_gate <= SlowClockGate & (w_state_nxt == ST_HOLD);
      end
   end

   assign SlowReq    = (r_state == ST_SWITCH) | (r_state == ST_HOLD);
   assign SlowWait   = w_hit & (r_state != ST_HOLD);
   assign ClockGate  = r_clock_gate;
   assign SlowActive = (r_state == ST_HOLD);

endmodule
